// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// Shift-add multiply and restoring divide run on sign magnitudes; the sign fix-up happens at writeback.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic                  divByZero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic           is_div, neg_res, neg_rem, div_zero;

  logic           sgn;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum, div_sh, div_diff;
  logic [W-1:0]   quot, rem;

  assign sgn   = ~op[2] & ~op[0];
  assign mag_a = (sgn && a[W-1]) ? -a : a;
  assign mag_b = (sgn && b[W-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign div_sh   = {acc[2*W-1:W], acc[W-1]};
  assign div_diff = div_sh - {1'b0, opnd};
  assign quot     = acc[W-1:0];
  assign rem      = acc[2*W-1:W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && !op[2]) state_nxt = op[1] ? DIV : MUL;
      MUL, DIV: if (cnt == '0) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (op)
            3'd4: hi <= a;
            3'd5: lo <= a;
            3'd0, 3'd1, 3'd2, 3'd3: begin
              busy     <= 1'b1;
              cnt      <= CW'(W-1);
              is_div   <= op[1];
              neg_res  <= sgn & (a[W-1] ^ b[W-1]);
              neg_rem  <= sgn & a[W-1];
              div_zero <= (b == '0);
              if (op[1]) begin
                acc  <= {{W{1'b0}}, mag_a};
                opnd <= mag_b;
              end else begin
                acc  <= {{W{1'b0}}, mag_b};
                opnd <= mag_a;
              end
            end
            default: ;
          endcase
        end
        MUL: begin
          acc <= {mul_sum, acc[W-1:1]};
          cnt <= cnt - 1'b1;
        end
        DIV: begin
          // Restore on a negative trial difference, otherwise keep it and shift in a 1.
          acc <= div_diff[W] ? {div_sh[W-1:0], acc[W-2:0], 1'b0}
                             : {div_diff[W-1:0], acc[W-2:0], 1'b1};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= neg_res ? -acc : acc;
          end else if (div_zero) begin
            divByZero <= 1'b1;
          end else begin
            lo <= neg_res ? -quot : quot;
            hi <= neg_rem ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: an arithmetic reference model checked every cycle,
// plus literal expectations for the hand-computed vectors.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clock, reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, divByZero;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_fail = 0;
  logic cmp_en;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {divByZero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp, sr;
    longint unsigned ux, uy, up, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd0: begin sp = sx * sy; return {1'b0, sp[63:32], sp[31:0]}; end
      3'd1: begin up = ux * uy; return {1'b0, up[63:32], up[31:0]}; end
      3'd2: begin
        if (y == 0) return {1'b1, 64'b0};
        sp = sx / sy; sr = sx % sy;
        return {1'b0, sr[31:0], sp[31:0]};
      end
      3'd3: begin
        if (y == 0) return {1'b1, 64'b0};
        up = ux / uy; ur = ux % uy;
        return {1'b0, ur[31:0], up[31:0]};
      end
      default: return 65'b0;
    endcase
  endfunction

  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_busy, m_done, m_dbz, p_dbz;
  int           m_cnt;

  // Model: an accepted iterative op retires 33 edges later; MTHI/MTLO write immediately.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_cnt <= 0; p_hi <= '0; p_lo <= '0; p_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (p_dbz) m_dbz <= 1'b1;
          else begin m_hi <= p_hi; m_lo <= p_lo; end
        end
      end else if (start) begin
        if (op == 3'd4) m_hi <= a;
        else if (op == 3'd5) m_lo <= a;
        else if (op < 3'd4) begin
          m_busy <= 1'b1;
          m_cnt  <= W + 1;
          {p_dbz, p_hi, p_lo} <= ref_result(op, a, b);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en && !reset) begin
      chk("model busy", busy, m_busy);
      chk("model done", done, m_done);
      chk("model divByZero", divByZero, m_dbz);
      chk("model hi", hi, m_hi);
      chk("model lo", lo, m_lo);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge, inputs scrambled.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  typedef struct { logic [2:0] o; logic [31:0] x, y, ehi, elo; } vec_t;
  vec_t vecs[5];
  int lat;
  logic saw_done;

  initial begin
    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd3, 32'd7,        32'd2,        32'd1,        32'd3};
    vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};

    cmp_en = 1'b0; reset = 1'b0; start = 1'b0; op = 3'd7; a = '0; b = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset divByZero", divByZero, 1'b0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cmp_en = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y);
      chk("busy after accept", busy, 1'b1);
      wait_done(lat);
      chk("latency", lat, 33);
      chk("vector hi", hi, vecs[i].ehi);
      chk("vector lo", lo, vecs[i].elo);
      chk("vector dbz", divByZero, 1'b0);
      @(negedge clock);
      chk("done one cycle", done, 1'b0);
    end

    issue(3'd4, 32'h11, 32'd0);
    chk("mthi hi", hi, 32'h11);
    issue(3'd5, 32'h22, 32'd0);
    chk("mtlo lo", lo, 32'h22);
    chk("mtlo busy", busy, 1'b0);
    issue(3'd2, 32'd5, 32'd0);
    repeat (5) @(negedge clock);
    issue(3'd4, 32'h99, 32'd0);
    chk("mthi while busy", hi, 32'h11);
    wait_done(lat);
    chk("div0 latency", lat, 27);
    chk("div0 flag", divByZero, 1'b1);
    chk("div0 hi kept", hi, 32'h11);
    chk("div0 lo kept", lo, 32'h22);

    issue(3'd6, 32'hDEAD, 32'd1);
    chk("noop busy", busy, 1'b0);
    chk("noop hi", hi, 32'h11);

    issue(3'd3, 32'd100, 32'd7);
    repeat (10) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midop reset busy", busy, 1'b0);
    chk("midop reset hi", hi, 32'd0);
    chk("midop reset lo", lo, 32'd0);
    chk("midop reset done", done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    chk("no activity after reset", saw_done, 1'b0);

    issue(3'd4, 32'h1234, 32'd0);
    chk("mthi after reset", hi, 32'h1234);
    chk("mthi no busy", busy, 1'b0);

    issue(3'd1, 32'h00010000, 32'h00010000);
    wait_done(lat);
    chk("b2b first latency", lat, 33);
    chk("b2b first hi", hi, 32'd1);
    chk("b2b first lo", lo, 32'd0);
    issue(3'd1, 32'h12345678, 32'h10);
    chk("b2b accepted in done cycle", busy, 1'b1);
    wait_done(lat);
    chk("b2b second latency", lat, 33);
    chk("b2b second hi", hi, 32'd1);
    chk("b2b second lo", lo, 32'h23456780);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit in the execute stage, alongside the ALU.
- Operands come straight from the register file read ports (outData1 → a, outData2 → b).
- Holds the architectural HI/LO registers for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO; MFHI/MFLO read the hi/lo outputs directly.
- The sequencer stalls the pipeline while busy is high.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted on a rising edge where start=1 and busy=0
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
- a  input  DATA_WIDTH  multiplicand / dividend / MTHI-MTLO source
- b  input  DATA_WIDTH  multiplier / divisor
- busy  output  1  iterative operation in progress
- done  output  1  one-cycle pulse when an iterative operation retires
- divByZero  output  1  qualifies done; high only with done for DIV/DIVU with b=0
- hi  output  DATA_WIDTH  HI register
- lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-operation):
  - state=IDLE; hi=lo=0; busy=done=divByZero=0; counter cleared; operation aborted.
- States: IDLE, MUL, DIV, FIX.
- IDLE, accepted start:
  - MTHI/MTLO write a into hi/lo at the accepting edge (edge 0) and stay in IDLE; busy and done stay 0.
  - op 6/7: ignored.
  - MULT/MULTU → MUL; DIV/DIVU → DIV.
  - a, b and signedness are captured at edge 0. Later input changes have no effect.
  - Signed ops convert operands to magnitudes and record the result signs.
  - counter=DATA_WIDTH-1; busy=1 after edge 0.
- MUL: one shift-add step per edge on a 2*DATA_WIDTH accumulator. At counter==0 → FIX; otherwise decrement.
- DIV: one restoring shift-subtract step per edge. At counter==0 → FIX.
- Iterations occupy edges 1..DATA_WIDTH.
- FIX (edge DATA_WIDTH+1), sign correction and writeback:
  - MUL: hi=upper half, lo=lower half of the product. Signed ops negate the 2*DATA_WIDTH result if the operand signs differ.
  - DIV: lo=quotient, hi=remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - -2^(W-1) / -1: lo=0x80000000 (wraps), hi=0. No flag.
  - Divide by zero: hi/lo unchanged, divByZero=1. Latency is identical (the iterations still run, results are discarded).
  - After edge DATA_WIDTH+1: done=1 for exactly one cycle, busy=0, state=IDLE. hi/lo are valid in that same cycle.
- Latency: 32-bit MULT/DIV results are visible 33 edges after the accepting edge.
- start while busy: ignored entirely (no queueing); hi/lo are not disturbed.
- start during the done cycle: accepted, because busy=0. The new operation begins at that edge.
- All outputs are registered. hi/lo hold their value between operations.

Test Plan:
- Reset: assert reset asynchronously with no clock edge → hi=lo=0, busy=0, done=0, divByZero=0 immediately.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF → busy for 33 edges; at edge 33 hi=0xFFFFFFFE, lo=0x00000001; done high exactly one cycle.
- MULT: a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Divides:
  - DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 → lo=3, hi=1.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero and busy rules:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV b=0 → divByZero=1 with done at edge 33; hi=0x11, lo=0x22 unchanged.
  - A second start with MTHI mid-operation is ignored; hi still 0x11.
- Reset mid-operation and back-to-back:
  - Start DIVU 100/7, assert reset after edge 10 → busy=0, hi=lo=0, no done pulse.
  - Then MTHI a=0x1234 → hi=0x1234 after one edge, busy never rises.
  - Back-to-back MULTU starting in the done cycle → second result 33 edges later.
